pc_call_stack: RTL
==================

// Module: pc_call_stack
// PURPOSE
//   Program counter with a built-in hardware return-address stack for subroutine call/return.
//   Supports absolute load, relative branch, increment by word size, call and return.
//   Sits in the fetch stage; data_o drives the instruction-memory address.
// PARAMETERS
//   DATA_WIDTH    16  PC / address width in bits
//   WORD_SIZE     1   increment step in addressable units
//   STACK_DEPTH   8   return-stack entries (>=2)
//   RESET_VECTOR  0   PC value loaded on reset
// PORTS
//   clk_i     in   1                          clock, rising edge
//   reset_i   in   1                          asynchronous reset, active-high
//   ld_ni     in   1                          absolute load of data_i (active-low)
//   call_ni   in   1                          push return address, jump to data_i (active-low)
//   ret_ni    in   1                          pop return address into PC (active-low)
//   rel_ni    in   1                          PC += signed data_i (active-low)
//   inc_ni    in   1                          PC += WORD_SIZE (active-low)
//   data_i    in   DATA_WIDTH                 target address or two's-complement offset
//   data_o    out  DATA_WIDTH                 current PC (registered)
//   depth_o   out  $clog2(STACK_DEPTH+1)      valid entries in return stack
//   ovf_o     out  1                          sticky: call attempted while stack full
//   unf_o     out  1                          sticky: return attempted while stack empty
// BEHAVIOUR
//   - Reset (async, any time, incl. mid-sequence): data_o=RESET_VECTOR, depth_o=0, ovf_o=0, unf_o=0.
//     Stack RAM contents not reset; they are unreadable until pushed.
//   - One operation per rising edge, fixed priority: ld > call > ret > rel > inc > hold.
//     Lower-priority strobes asserted in the same cycle are ignored, no side effects.
//   - Results are visible on data_o/depth_o immediately after the edge (1-cycle latency).
//   - ld:   PC <= data_i.
//   - call: if depth<STACK_DEPTH: stack[depth] <= PC+WORD_SIZE, depth++, PC <= data_i.
//           if full: PC, stack and depth unchanged; ovf_o <= 1.
//   - ret:  if depth>0: PC <= stack[depth-1], depth--.
//           if empty: PC and depth unchanged; unf_o <= 1.
//   - rel:  PC <= PC + data_i (data_i signed); inc: PC <= PC + WORD_SIZE.
//   - All PC arithmetic is modulo 2**DATA_WIDTH; wrap-around is silent.
//     Return address of a call at the top address wraps to 0+WORD_SIZE-1.
//   - ovf_o/unf_o are sticky; cleared only by reset.
//   - The stack is strictly LIFO. No simultaneous push+pop (priority excludes it).
// STRUCTURE
//   - Package pc_pkg:
//     - enum pc_op_e {OP_HOLD, OP_INC, OP_REL, OP_RET, OP_CALL, OP_LD}
//     - function pc_decode(ld_n, call_n, ret_n, rel_n, inc_n) returns pc_op_e per the priority above
//   - Sub-module return_stack: DEPTH x DATA_WIDTH LIFO; push_i, pop_i, wdata_i, top_o, depth_o,
//     full_o, empty_o. Pointer register + array; pointer reset async to 0.
//   - Top level: decode, PC register, adder mux, sticky flag registers.
// TESTING
//   1 Reset with inc_ni=0 held -> data_o=RESET_VECTOR while reset_i=1; first edge after release -> 0x0001.
//   2 ld_ni=0, data_i=0x00A0 -> data_o=0x00A0. Then rel_ni=0, data_i=0xFFF0 -> 0x0090; 0x0010 -> 0x00A0.
//   3 PC=0x0010, call data_i=0x0200 -> data_o=0x0200, depth_o=1.
//     Then ret -> data_o=0x0011, depth_o=0.
//   4 Eight nested calls from PCs 0x10..0x17 -> depth_o=8. Ninth call -> PC unchanged, ovf_o=1.
//     Eight rets unwind in reverse order: 0x18..0x11.
//   5 ret with depth_o=0 -> data_o unchanged, unf_o=1 (stays 1 after later valid ops).
//   6 ld_ni=0 and call_ni=0 same cycle -> load only, depth_o unchanged.
//     PC=0xFFFF inc -> 0x0000. reset_i pulsed mid-call sequence -> all outputs at reset values.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and decode for the fetch-stage PC.
// Operation priority: ld > call > ret > rel > inc > hold.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_REL,
    OP_RET,
    OP_CALL,
    OP_LD
  } pc_op_e;

  function automatic pc_op_e pc_decode(
    input logic ld_n,
    input logic call_n,
    input logic ret_n,
    input logic rel_n,
    input logic inc_n
  );
    pc_op_e op;
    if (!ld_n)        op = OP_LD;
    else if (!call_n) op = OP_CALL;
    else if (!ret_n)  op = OP_RET;
    else if (!rel_n)  op = OP_REL;
    else if (!inc_n)  op = OP_INC;
    else              op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses; the entries themselves are not reset.
// Pushes when full and pops when empty are ignored.
module return_stack #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  localparam int PW = $clog2(DEPTH + 1),
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] top_o,
  output logic [PW-1:0]         depth_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         ptr_m1;
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_idx;
  logic                  do_push;
  logic                  do_pop;

  assign full_o  = (ptr == PW'(DEPTH));
  assign empty_o = (ptr == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o && !push_i;
  assign ptr_m1  = ptr - PW'(1);
  assign wr_idx  = ptr[IW-1:0];
  assign rd_idx  = ptr_m1[IW-1:0];
  assign top_o   = mem[rd_idx];
  assign depth_o = ptr;

  // Pointer: counts valid entries, cleared asynchronously.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)      ptr <= '0;
    else if (do_push) ptr <= ptr + PW'(1);
    else if (do_pop)  ptr <= ptr_m1;
  end

  // Entry storage: written on a push into the next free slot.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_idx] <= wdata_i;
  end

endmodule

// File: rtl/pc_call_stack.sv
// Fetch-stage program counter with hardware return-address stack.
// data_o is the registered PC and drives the instruction address.
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int WORD_SIZE    = 1,
  parameter int STACK_DEPTH  = 8,
  parameter int RESET_VECTOR = 0,
  localparam int DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  ld_ni,
  input  logic                  call_ni,
  input  logic                  ret_ni,
  input  logic                  rel_ni,
  input  logic                  inc_ni,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [DW-1:0]         depth_o,
  output logic                  ovf_o,
  output logic                  unf_o
);

  localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(WORD_SIZE);
  localparam logic [DATA_WIDTH-1:0] RVEC = DATA_WIDTH'(RESET_VECTOR);

  pc_op_e                op;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_nxt;
  logic [DATA_WIDTH-1:0] ret_addr;
  logic [DATA_WIDTH-1:0] top;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  assign op       = pc_decode(ld_ni, call_ni, ret_ni, rel_ni, inc_ni);
  assign ret_addr = pc + STEP;
  assign push     = (op == OP_CALL) && !full;
  assign pop      = (op == OP_RET) && !empty;

  return_stack #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (STACK_DEPTH)
  ) u_stack (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (ret_addr),
    .top_o   (top),
    .depth_o (depth_o),
    .full_o  (full),
    .empty_o (empty)
  );

  // Next-PC select; blocked call/ret leave the PC where it is.
  always_comb begin
    pc_nxt = pc;
    unique case (op)
      OP_LD:   pc_nxt = data_i;
      OP_CALL: if (!full) pc_nxt = data_i;
      OP_RET:  if (!empty) pc_nxt = top;
      OP_REL:  pc_nxt = pc + data_i;
      OP_INC:  pc_nxt = pc + STEP;
      default: pc_nxt = pc;
    endcase
  end

  // PC register and sticky overflow/underflow flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc    <= RVEC;
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (op == OP_CALL && full)  ovf_o <= 1'b1;
      if (op == OP_RET && empty) unf_o <= 1'b1;
    end
  end

  assign data_o = pc;

endmodule
